// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encoding
// and the default pattern register width.
package seq_gen_pkg;

    localparam int unsigned PW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag. Used for both the bit counter
// and the repetition counter of the pattern generator.
module seq_bit_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends pattern[len:0] MSB-first, repeated
// reps+1 times with gap idle cycles between repetitions, then pulses done.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned PW = PW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PW-1:0]         pattern,
    input  logic [$clog2(PW)-1:0] len,
    input  logic [3:0]            reps,
    input  logic [1:0]            gap,
    output logic                  out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned  LW  = $clog2(PW);
    localparam logic [LW-1:0] TOP = LW'(PW - 1);

    state_t        state;
    logic [PW-1:0] pat_r;     // captured pattern, active MSB aligned to bit PW-1
    logic [PW-1:0] sh;        // bits still to send in the current repetition
    logic [LW-1:0] len_r;
    logic [1:0]    gap_r;
    logic [1:0]    gap_cnt;

    logic [PW-1:0] aligned;
    logic [LW-1:0] bit_load_value;
    logic          bit_load, bit_dec, bit_zero;
    logic          rep_load, rep_dec, rep_zero;

    // Left-align the active bits so the shift path always reads bit PW-1.
    always_comb begin
        aligned = pattern << (TOP - len);
    end

    // Counter control derived from the current state and counter flags.
    always_comb begin
        bit_load       = 1'b0;
        bit_dec        = 1'b0;
        rep_load       = 1'b0;
        rep_dec        = 1'b0;
        bit_load_value = (state == IDLE) ? len : len_r;
        case (state)
            IDLE: begin
                if (start) begin
                    bit_load = 1'b1;
                    rep_load = 1'b1;
                end
            end
            SHIFT: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (!rep_zero) begin
                    rep_dec = 1'b1;
                    if (gap_r == '0) begin
                        bit_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    bit_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    seq_bit_counter #(.W(LW)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (bit_load),
        .load_value (bit_load_value),
        .dec        (bit_dec),
        .zero       (bit_zero)
    );

    seq_bit_counter #(.W(4)) u_rep_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (rep_load),
        .load_value (reps),
        .dec        (rep_dec),
        .zero       (rep_zero)
    );

    // Moore FSM with registered outputs; the bit on out matches the state shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_r     <= '0;
            sh        <= '0;
            len_r     <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        pat_r     <= aligned;
                        sh        <= aligned << 1;
                        len_r     <= len;
                        gap_r     <= gap;
                        out       <= aligned[PW-1];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bit_zero) begin
                        out <= sh[PW-1];
                        sh  <= sh << 1;
                    end else if (!rep_zero) begin
                        if (gap_r == '0) begin
                            out <= pat_r[PW-1];
                            sh  <= pat_r << 1;
                        end else begin
                            gap_cnt   <= gap_r - 2'd1;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            state     <= GAP;
                        end
                    end else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        out       <= pat_r[PW-1];
                        sh        <= pat_r << 1;
                        out_valid <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PW, default 8, SHALL set the pattern register width in bits (supported range 2..16).
REQ-002 clk  in  1  SHALL be the clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  in  1  SHALL request a transmission and SHALL be sampled only in IDLE.
REQ-005 pattern  in  PW  SHALL carry the bits to send, captured when start is accepted.
REQ-006 len  in  $clog2(PW)  SHALL give the active bit count minus 1 (len=2 means 3 bits), captured with pattern.
REQ-007 reps  in  4  SHALL give the repetition count minus 1 (0 means 1 transmission), captured with pattern.
REQ-008 gap  in  2  SHALL give the idle-zero cycles inserted between repetitions, captured with pattern.
REQ-009 out  out  1  SHALL carry the serial data bit, registered.
REQ-010 out_valid  out  1  SHALL be high exactly in cycles where out carries a pattern bit.
REQ-011 busy  out  1  SHALL be high from the cycle after acceptance through the DONE cycle inclusive.
REQ-012 done  out  1  SHALL be a single-cycle pulse marking completion of the final repetition.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT, GAP and DONE, with all outputs registered (Moore).
REQ-014 IDLE: when start=1, the block SHALL capture pattern, len, reps and gap and SHALL go to SHIFT on the next edge.
REQ-015 SHIFT: the block SHALL send bits pattern[len] down to pattern[0], MSB-first, one bit per cycle, with out_valid=1.
REQ-016 Latency: the first bit SHALL appear on out in the cycle directly after the start acceptance edge.
REQ-017 Bits of pattern above index len SHALL be ignored.
REQ-018 After bit 0, if repetitions remain and gap>0, the FSM SHALL enter GAP for exactly gap cycles with out=0 and out_valid=0, then return to SHIFT.
REQ-019 After bit 0, if repetitions remain and gap=0, the next repetition's MSB SHALL follow bit 0 back-to-back with no bubble.
REQ-020 After bit 0 of the last repetition, the FSM SHALL enter DONE for one cycle with done=1, busy=1, out=0 and out_valid=0, then go to IDLE.
REQ-021 start SHALL be ignored in SHIFT, GAP and DONE; inputs changing there SHALL NOT affect the transmission in progress.
REQ-022 The bit counter SHALL count down from len to 0; the repetition counter SHALL count down from reps to 0; neither SHALL wrap.
REQ-023 A minimum transmission (len=0, reps=0) SHALL produce one valid bit, then DONE.
REQ-024 A maximum transmission (len=PW-1, reps=15, gap=3) SHALL produce 16*PW valid bits and 45 gap cycles.
REQ-025 In IDLE, out, out_valid, busy and done SHALL all be 0.

Reset
REQ-026 rst=1 SHALL force state IDLE and out=0, out_valid=0, busy=0, done=0, and clear all counters and captured registers on the same edge.
REQ-027 rst asserted mid-transmission (SHIFT or GAP) SHALL abort with no done pulse; start in the cycle after rst deasserts SHALL be accepted normally.
REQ-028 rst SHALL take priority over start when both are high.

Structure
REQ-029 A shared package seq_gen_pkg SHALL hold the state encoding constants (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the default PW.
REQ-030 A single sub-module seq_bit_counter (loadable down-counter with a zero flag) SHALL be instantiated for both the bit counter and the repetition counter.
REQ-031 The shift path SHALL use an index or shift register of width PW; no combinational path SHALL exist from an input to out.

Verification
REQ-032 pattern=8'b0000_0100, len=2, reps=0, gap=0, start pulse -> out=1,0,0 with out_valid high 3 cycles; done in the 4th cycle; busy high 4 cycles.
REQ-033 pattern=8'b0000_0100, len=2, reps=2, gap=0 -> stream 100100100 contiguous (9 valid cycles); a downstream "100" overlap detector pulses 3 times.
REQ-034 pattern=8'b1011_0001, len=7, reps=1, gap=2 -> 10110001, 2 cycles out_valid=0, 10110001, then done.
REQ-035 start held high continuously with len=0, reps=0 -> one transmission per 3 cycles (IDLE, SHIFT, DONE); start during SHIFT or DONE ignored.
REQ-036 rst asserted in the 3rd SHIFT cycle of len=7 -> next cycle all outputs 0, no done; a new start afterwards transmits correctly.
REQ-037 len=0, reps=15, gap=0, pattern bit0=1 -> 16 consecutive valid 1s, then one done pulse.
